// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one instruction word from instruction memory at the address given by
// the PC. The word travels over a req/ack handshake and is latched into the
// instruction register (IR). The control FSM pulses fetch_start. This block
// answers with fetch_done once ir_out holds the new word, or with fetch_err if
// the fetch timed out. A flush abandons the fetch in flight and drops its data.
//
// Optional feature:
//   FETCH_TIMEOUT_EN  When defined, a fetch aborts with a fetch_err pulse after
//                     TIMEOUT request cycles that see no ack. When undefined,
//                     the unit waits for an ack indefinitely and fetch_err is
//                     tied to 0.
//
// Parameters:
//   ADDR_W   width of the PC and of the memory address
//   DATA_W   width of an instruction word
//   TIMEOUT  number of request cycles without an ack before the fetch aborts
//            (used only with FETCH_TIMEOUT_EN; legal range 1..255)
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pc_in        fetch address; sampled only when a fetch_start is accepted
//   fetch_start  request one fetch; accepted only while idle
//   flush        abort any fetch in progress and discard its data
//   mem_req      read request to instruction memory
//   mem_addr     read address; stable while mem_req is high
//   mem_ack      memory returns data this cycle (ignored unless mem_req is high)
//   mem_rdata    instruction word; valid when mem_ack is high
//   ir_out       instruction register
//   fetch_done   one-cycle pulse; ir_out has just been updated
//   busy         fetch in flight (always equal to mem_req)
//   fetch_err    one-cycle pulse; the fetch was aborted by timeout
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              fetch_done,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state;

  // busy is defined to be mem_req. Driving it from the same flop keeps the
  // two outputs identical in every cycle, including during reset.
  assign busy = mem_req;

`ifdef FETCH_TIMEOUT_EN
  // The value the wait counter holds in the last request cycle before the
  // fetch gives up. The counter is 0 in the first request cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only. Every
  // register in this block sees the values from before the clock edge, which
  // matches the flop-to-flop behaviour of the hardware.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ir_out     <= '0;
      fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      // The status pulses last one cycle. They are cleared here and set again
      // only by the branch that completes or aborts a fetch.
      fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
`endif

      unique case (state)
        IDLE: begin
          // flush beats a simultaneous start: the redirect makes pc_in stale.
          if (fetch_start && !flush) begin
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state    <= REQ;
          end
        end

        REQ: begin
          // fetch_start is ignored here. A new fetch is not queued.
          if (flush) begin
            // Data that arrives in the flush cycle belongs to the old stream.
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (mem_ack) begin
            ir_out     <= mem_rdata;
            fetch_done <= 1'b1;
            mem_req    <= 1'b0;
            state      <= IDLE;
`ifdef FETCH_TIMEOUT_EN
          end else if (wait_cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed testbench for instr_fetch_unit. The expected values are worked out
// by hand from the handshake timing. Inputs change 1 ns after a rising edge,
// and outputs are sampled at that same point. The timeout checks follow
// FETCH_TIMEOUT_EN, so the bench matches the way the design is built.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] pc_in;
  logic              fetch_start;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic              fetch_done;
  logic              busy;
  logic              fetch_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .fetch_start (fetch_start),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_out      (ir_out),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count fetch_done pulses halfway between rising edges.
  always @(negedge clock) if (fetch_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base_done;
    int lost_req;

    reset_n     = 1'b0;
    pc_in       = '0;
    fetch_start = 1'b0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    repeat (2) step();

    // Reset state
    check("rst_mem_req",  32'(mem_req),    32'h0);
    check("rst_busy",     32'(busy),       32'h0);
    check("rst_mem_addr", 32'(mem_addr),   32'h0);
    check("rst_ir_out",   32'(ir_out),     32'h0);
    check("rst_done",     32'(fetch_done), 32'h0);
    check("rst_err",      32'(fetch_err),  32'h0);
    reset_n = 1'b1;
    step();

    // Zero-wait fetch. The early ack is ignored while the unit is idle.
    pc_in = 16'h0040; fetch_start = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    step();                                     // E0
    fetch_start = 1'b0;
    check("zw_req_e0",  32'(mem_req),    32'h1);
    check("zw_busy_e0", 32'(busy),       32'h1);
    check("zw_addr_e0", 32'(mem_addr),   32'h0040);
    check("zw_done_e0", 32'(fetch_done), 32'h0);
    step();                                     // E1
    check("zw_ir_e1",   32'(ir_out),     32'hA5C3);
    check("zw_done_e1", 32'(fetch_done), 32'h1);
    check("zw_req_e1",  32'(mem_req),    32'h0);
    check("zw_busy_e1", 32'(busy),       32'h0);
    mem_ack = 1'b0;
    step();
    check("zw_done_off", 32'(fetch_done), 32'h0);
    check("zw_busy_off", 32'(busy),       32'h0);

    // Three wait states, then a back-to-back start in the fetch_done cycle.
    pc_in = 16'h0100; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; pc_in = 16'hDEAD;
    check("ws_addr", 32'(mem_addr), 32'h0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ws_req_w%0d", i),  32'(mem_req),    32'h1);
      check($sformatf("ws_done_w%0d", i), 32'(fetch_done), 32'h0);
      check($sformatf("ws_addr_w%0d", i), 32'(mem_addr),   32'h0100);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    check("ws_ir",   32'(ir_out),     32'h1234);
    check("ws_done", 32'(fetch_done), 32'h1);
    check("ws_req",  32'(mem_req),    32'h0);
    mem_ack = 1'b0; fetch_start = 1'b1; pc_in = 16'h0041;
    step();
    fetch_start = 1'b0;
    check("b2b_req",  32'(mem_req),  32'h1);
    check("b2b_addr", 32'(mem_addr), 32'h0041);
    mem_ack = 1'b1; mem_rdata = 16'h5678;
    step();
    mem_ack = 1'b0;
    check("b2b_ir",   32'(ir_out),     32'h5678);
    check("b2b_done", 32'(fetch_done), 32'h1);

    // A flush arrives in the same cycle as an ack. The data must be dropped.
    pc_in = 16'h0200; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("fl_req_on", 32'(mem_req), 32'h1);
    base_done = done_cnt;
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    check("fl_req",  32'(mem_req),    32'h0);
    check("fl_done", 32'(fetch_done), 32'h0);
    check("fl_ir",   32'(ir_out),     32'h5678);
    flush = 1'b0; mem_ack = 1'b0;
    step();
    check("fl_ir_hold", 32'(ir_out), 32'h5678);
    check("fl_no_done", 32'(done_cnt - base_done), 32'h0);
    // flush and fetch_start together while idle: no request is issued.
    flush = 1'b1; fetch_start = 1'b1; pc_in = 16'h0BAD;
    step();
    flush = 1'b0; fetch_start = 1'b0;
    check("fls_req",  32'(mem_req),  32'h0);
    check("fls_addr", 32'(mem_addr), 32'h0200);
    step();
    check("fls_req2", 32'(mem_req),  32'h0);

    // fetch_start during REQ is ignored.
    base_done = done_cnt;
    pc_in = 16'h0300; fetch_start = 1'b1;
    step();
    pc_in = 16'h03FF;              // fetch_start stays high for two more cycles
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("ig_addr_%0d", i), 32'(mem_addr), 32'h0300);
      check($sformatf("ig_req_%0d", i),  32'(mem_req),  32'h1);
    end
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    check("ig_ir", 32'(ir_out), 32'hBEEF);
    step();
    check("ig_req_after", 32'(mem_req), 32'h0);
    step();
    check("ig_one_done", 32'(done_cnt - base_done), 32'h1);

`ifdef FETCH_TIMEOUT_EN
    // No ack: fetch_err pulses after the 4th request cycle.
    pc_in = 16'h0400; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      check($sformatf("to_req_%0d", i), 32'(mem_req),   32'h1);
      check($sformatf("to_err_%0d", i), 32'(fetch_err), 32'h0);
    end
    step();
    check("to_err",  32'(fetch_err),  32'h1);
    check("to_req",  32'(mem_req),    32'h0);
    check("to_done", 32'(fetch_done), 32'h0);
    check("to_ir",   32'(ir_out),     32'hBEEF);
    step();
    check("to_err_off", 32'(fetch_err), 32'h0);
    // An ack in the 4th request cycle wins over the timeout.
    pc_in = 16'h0500; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    repeat (TIMEOUT - 1) step();
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    step();
    mem_ack = 1'b0;
    check("tk_done", 32'(fetch_done), 32'h1);
    check("tk_err",  32'(fetch_err),  32'h0);
    check("tk_ir",   32'(ir_out),     32'h0F0F);
`else
    // Without the timeout, the request is still pending after 100 cycles.
    pc_in = 16'h0400; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    lost_req = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_req !== 1'b1 || fetch_err !== 1'b0 || fetch_done !== 1'b0) lost_req++;
    end
    check("nto_waiting", 32'(lost_req), 32'h0);
    check("nto_addr",    32'(mem_addr), 32'h0400);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("nto_flush", 32'(mem_req), 32'h0);
`endif

    // Reset during an active request drops mem_req at once.
    pc_in = 16'h0600; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("ar_req_on", 32'(mem_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_req",  32'(mem_req),  32'h0);
    check("ar_busy", 32'(busy),     32'h0);
    check("ar_ir",   32'(ir_out),   32'h0);
    check("ar_addr", 32'(mem_addr), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    check("ar_idle_req",  32'(mem_req),    32'h0);
    check("ar_idle_done", 32'(fetch_done), 32'h0);
    check("ar_idle_ir",   32'(ir_out),     32'h0);
    mem_ack = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
